register_bank: RTL and testbench
================================

REGISTER_BANK -- requirements
Module: register_bank

Interface
REQ-001 SHALL have parameter ADRSIZE, default 8, address width.
REQ-002 SHALL have parameter REGSIZE, default 32, register width; must be a multiple of 8.
REQ-003 SHALL have parameter NREGS, default 8, number of registers (1..2^ADRSIZE).
REQ-004 SHALL have parameter BASEADR, default 0, address of register 0.
REQ-005 SHALL have parameter INIT, default all zeros, NREGS*REGSIZE reset values; slice i belongs to register i.
REQ-006 SHALL have parameter MODE, default all zeros, 2*NREGS bits; per register: 0=RW, 1=RO, 2=W1C, 3=PULSE.
REQ-007 SHALL have port: clock  in  1  rising-edge clock.
REQ-008 SHALL have port: reset  in  1  reset, synchronous, active-high.
REQ-009 SHALL have port: wr  in  1  write strobe.
REQ-010 SHALL have port: rd  in  1  read strobe.
REQ-011 SHALL have port: adr  in  ADRSIZE  access address.
REQ-012 SHALL have port: bus_wr  in  REGSIZE  write data.
REQ-013 SHALL have port: byte_en  in  REGSIZE/8  write byte enables.
REQ-014 SHALL have port: status_in  in  NREGS*REGSIZE  RO source / W1C set inputs.
REQ-015 SHALL have port: data_out  out  NREGS*REGSIZE  current register contents.
REQ-016 SHALL have port: bus_rd  out  REGSIZE  registered read data.
REQ-017 SHALL have port: rd_valid  out  1  one-cycle read-data qualifier.
REQ-018 SHALL have port: ack  out  1  one-cycle access acknowledge.
REQ-019 SHALL have port: err  out  1  one-cycle access error.

Function
REQ-020 Hit SHALL be BASEADR <= adr <= BASEADR+NREGS-1; index = adr-BASEADR.
REQ-021 RW: on wr and hit, each byte with byte_en set SHALL load bus_wr on the next edge; other bytes hold.
REQ-022 RO: data_out slice SHALL register status_in slice every cycle; writes ignored.
REQ-023 W1C: bit SHALL set on any cycle its status_in bit is 1 (sticky); written 1 under byte_en clears it; set wins over simultaneous clear.
REQ-024 PULSE: enabled written bits SHALL be 1 for exactly one cycle after the write edge, then 0; unenabled bits 0.
REQ-025 Read: rd at cycle N SHALL drive bus_rd with the register value as of cycle N and rd_valid=1 at N+1; bus_rd holds otherwise.
REQ-026 rd and wr to same register in same cycle SHALL return the pre-write value.
REQ-027 Read miss SHALL return bus_rd=0 with rd_valid=1.
REQ-028 ack SHALL pulse at N+1 for any wr or rd hit at N, single pulse if both.
REQ-029 err SHALL pulse at N+1 for any wr/rd miss or wr to an RO register at N; ack and err never both 1.
REQ-030 Back-to-back accesses every cycle SHALL be supported with no stall.
REQ-031 Write with byte_en=0 SHALL change nothing but still ack.

Reset
REQ-032 On reset, RW and W1C registers SHALL load INIT; PULSE registers SHALL be 0; RO registers SHALL be 0 until first post-reset cycle.
REQ-033 On reset, bus_rd=0, rd_valid=0, ack=0, err=0.
REQ-034 Reset SHALL override wr, rd and status_in in the same cycle; an access issued in the cycle before reset deasserts produces no response.

Verification
REQ-035 Defaults, INIT reg1=0x12345678: wr adr=1 bus_wr=0xAABBCCDD byte_en=0101 -> reg1=0x12BB56DD, ack at N+1.
REQ-036 reg2 W1C: status_in bit0=1 one cycle, then wr 0x1 while status_in bit0=1 -> bit0 stays 1; repeat with status_in=0 -> bit0=0.
REQ-037 reg3 PULSE: wr 0x80000001 byte_en=1111 -> data_out reg3=0x80000001 one cycle, then 0.
REQ-038 rd adr=8 (miss) -> bus_rd=0, rd_valid=1, err=1, ack=0 at N+1; wr to RO reg -> err=1, value unchanged.
REQ-039 rd+wr same cycle adr=0 value 0x5 over 0x0 -> bus_rd=0x0, following rd -> 0x5; reset asserted mid-burst -> all outputs per REQ-032/033.

Source files
------------

// File: rtl/register_bank.sv
// Parameterised bank of memory-mapped registers. Each register can be RW, RO,
// W1C or PULSE. Reads, acknowledges and errors are returned one cycle after the access.
module register_bank #(
  parameter int ADRSIZE = 8,
  parameter int REGSIZE = 32,
  parameter int NREGS   = 8,
  parameter int BASEADR = 0,
  parameter logic [NREGS*REGSIZE-1:0] INIT = '0,
  parameter logic [2*NREGS-1:0]       MODE = '0
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     wr,
  input  logic                     rd,
  input  logic [ADRSIZE-1:0]       adr,
  input  logic [REGSIZE-1:0]       bus_wr,
  input  logic [REGSIZE/8-1:0]     byte_en,
  input  logic [NREGS*REGSIZE-1:0] status_in,
  output logic [NREGS*REGSIZE-1:0] data_out,
  output logic [REGSIZE-1:0]       bus_rd,
  output logic                     rd_valid,
  output logic                     ack,
  output logic                     err
);

  localparam int NBYTES = REGSIZE / 8;
  localparam int IDXW   = (NREGS > 1) ? $clog2(NREGS) : 1;

  localparam logic [1:0] M_RW    = 2'd0;
  localparam logic [1:0] M_RO    = 2'd1;
  localparam logic [1:0] M_W1C   = 2'd2;
  localparam logic [1:0] M_PULSE = 2'd3;

  function automatic logic [REGSIZE-1:0] byte_mask(input logic [NBYTES-1:0] be);
    logic [REGSIZE-1:0] m;
    m = '0;
    for (int b = 0; b < NBYTES; b++) m[b*8 +: 8] = {8{be[b]}};
    return m;
  endfunction

  logic                hit;
  logic [IDXW-1:0]     idx;
  logic [REGSIZE-1:0]  wr_mask;
  logic [REGSIZE-1:0]  rd_word;
  logic                ro_hit;
  logic                ro_wr;
  logic                unused_status;

  // Status bits only matter for RO and W1C registers; the rest are ignored.
  assign unused_status = ^status_in;

  assign hit     = (64'(adr) >= 64'(BASEADR)) && (64'(adr) < 64'(BASEADR) + 64'(NREGS));
  assign idx     = IDXW'(adr - ADRSIZE'(BASEADR));
  assign wr_mask = byte_mask(byte_en);

  always_comb begin
    rd_word = '0;
    ro_hit  = 1'b0;
    for (int i = 0; i < NREGS; i++) begin
      if (hit && (idx == IDXW'(i))) begin
        rd_word = data_out[i*REGSIZE +: REGSIZE];
        ro_hit  = (MODE[2*i +: 2] == M_RO);
      end
    end
  end

  assign ro_wr = wr && ro_hit;

  for (genvar i = 0; i < NREGS; i++) begin : g_reg
    localparam logic [1:0] M = MODE[2*i +: 2];
    logic [REGSIZE-1:0] q;
    logic [REGSIZE-1:0] wmask;

    assign wmask = (wr && hit && (idx == IDXW'(i))) ? wr_mask : '0;

    // W1C: an incoming status bit wins over a simultaneous write-one clear.
    always_ff @(posedge clock) begin
      if (reset) begin
        q <= ((M == M_RW) || (M == M_W1C)) ? INIT[i*REGSIZE +: REGSIZE] : '0;
      end else begin
        case (M)
          M_RW:    q <= (q & ~wmask) | (bus_wr & wmask);
          M_RO:    q <= status_in[i*REGSIZE +: REGSIZE];
          M_W1C:   q <= (q & ~(bus_wr & wmask)) | status_in[i*REGSIZE +: REGSIZE];
          default: q <= bus_wr & wmask;
        endcase
      end
    end

    assign data_out[i*REGSIZE +: REGSIZE] = q;
  end

  // Response stage: rd_word is sampled before this edge's write lands.
  always_ff @(posedge clock) begin
    if (reset) begin
      bus_rd   <= '0;
      rd_valid <= 1'b0;
      ack      <= 1'b0;
      err      <= 1'b0;
    end else begin
      rd_valid <= rd;
      if (rd) bus_rd <= rd_word;
      ack <= hit && (wr || rd) && !ro_wr;
      err <= ((wr || rd) && !hit) || ro_wr;
    end
  end

endmodule

// File: tb/tb_register_bank.sv
// Bench for register_bank: hand-computed vector table, reset corner cases, and
// randomized traffic checked against a behavioural model of the register rules.
module tb_register_bank;

  localparam int NR = 8;
  localparam logic [255:0] INIT_P = {32'h0, 32'h000000F0, 32'hCAFEF00D, 32'h0,
                                     32'h0, 32'h0, 32'h12345678, 32'h0};
  // r7..r0 = RO, W1C, RW, RO, PULSE, W1C, RW, RW
  localparam logic [15:0] MODE_P = 16'b01_10_00_01_11_10_00_00;

  int          mode_of [NR] = '{0, 0, 2, 3, 1, 0, 2, 1};
  logic [31:0] init_of [NR] = '{32'h0, 32'h12345678, 32'h0, 32'h0,
                                32'h0, 32'hCAFEF00D, 32'h000000F0, 32'h0};

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         wr = 1'b0, rd = 1'b0;
  logic [7:0]   adr = '0;
  logic [31:0]  bus_wr = '0;
  logic [3:0]   byte_en = '0;
  logic [255:0] status_in = '0;
  logic [255:0] data_out;
  logic [31:0]  bus_rd;
  logic         rd_valid, ack, err;

  register_bank #(
    .ADRSIZE(8), .REGSIZE(32), .NREGS(NR), .BASEADR(0),
    .INIT(INIT_P), .MODE(MODE_P)
  ) dut (
    .clock(clock), .reset(reset), .wr(wr), .rd(rd), .adr(adr),
    .bus_wr(bus_wr), .byte_en(byte_en), .status_in(status_in),
    .data_out(data_out), .bus_rd(bus_rd), .rd_valid(rd_valid),
    .ack(ack), .err(err)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] m [NR];
  logic [31:0] e_bus_rd;
  logic        e_rv, e_ack, e_err;

  task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // One clock of the reference behaviour, computed from the register rules.
  task automatic model_step(input logic rst, input logic w, input logic r,
                            input logic [7:0] a, input logic [31:0] d,
                            input logic [3:0] be, input logic [255:0] st);
    logic [31:0] mask, s;
    logic        h, ro_w;
    int          i;
    if (rst) begin
      for (int j = 0; j < NR; j++)
        m[j] = (mode_of[j] == 0 || mode_of[j] == 2) ? init_of[j] : 32'h0;
      e_bus_rd = '0; e_rv = 0; e_ack = 0; e_err = 0;
      return;
    end
    h = (a < NR);
    i = int'(a);
    mask = 0;
    for (int b = 0; b < 4; b++) if (be[b]) mask = mask | (32'hFF << (8*b));
    e_rv = r;
    if (r) e_bus_rd = h ? m[i] : 32'h0;
    ro_w  = w && h && (mode_of[i] == 1);
    e_ack = h && (w || r) && !ro_w;
    e_err = ((w || r) && !h) || ro_w;
    for (int j = 0; j < NR; j++) begin
      s = st[j*32 +: 32];
      case (mode_of[j])
        0: if (w && h && i == j) m[j] = (m[j] & ~mask) | (d & mask);
        1: m[j] = s;
        2: m[j] = ((w && h && i == j) ? (m[j] & ~(d & mask)) : m[j]) | s;
        default: m[j] = (w && h && i == j) ? (d & mask) : 32'h0;
      endcase
    end
  endtask

  task automatic cycle(input logic rst, input logic w, input logic r,
                       input logic [7:0] a, input logic [31:0] d,
                       input logic [3:0] be, input logic [255:0] st);
    logic [255:0] packed_m;
    reset = rst; wr = w; rd = r; adr = a; bus_wr = d; byte_en = be; status_in = st;
    @(posedge clock);
    model_step(rst, w, r, a, d, be, st);
    #1;
    for (int j = 0; j < NR; j++) packed_m[j*32 +: 32] = m[j];
    check("ack", 256'(ack), 256'(e_ack));
    check("err", 256'(err), 256'(e_err));
    check("rd_valid", 256'(rd_valid), 256'(e_rv));
    check("bus_rd", 256'(bus_rd), 256'(e_bus_rd));
    check("data_out", data_out, packed_m);
  endtask

  typedef struct {
    logic         w, r;
    logic [7:0]   a;
    logic [31:0]  d;
    logic [3:0]   be;
    logic [255:0] st;
    logic         x_ack, x_err, x_rv;
    logic [31:0]  x_brd;
    int           ci;
    logic [31:0]  creg;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic w, input logic r, input logic [7:0] a, input logic [31:0] d,
                     input logic [3:0] be, input logic [255:0] st, input logic x_ack,
                     input logic x_err, input logic x_rv, input logic [31:0] x_brd,
                     input int ci, input logic [31:0] creg);
    vq.push_back('{w, r, a, d, be, st, x_ack, x_err, x_rv, x_brd, ci, creg});
  endtask

  initial begin
    logic [255:0] st;

    // Reset state
    cycle(1, 1, 1, 8'd1, 32'hFFFFFFFF, 4'hF, '1);
    check("reset_data_out", data_out, INIT_P);
    check("reset_ack_err", {ack, err, rd_valid}, 3'b000);

    //  w r adr  data          be      status               ack err rv bus_rd   reg value
    add(1, 0, 1, 32'hAABBCCDD, 4'b0101, '0,                  1, 0, 0, 32'h0,        1, 32'h12BB56DD);
    add(0, 1, 1, 32'h0,        4'h0,   '0,                  1, 0, 1, 32'h12BB56DD, 1, 32'h12BB56DD);
    add(0, 0, 0, 32'h0,        4'h0,   256'(1) << 64,       0, 0, 0, 32'h12BB56DD, 2, 32'h1);
    add(1, 0, 2, 32'h1,        4'hF,   256'(1) << 64,       1, 0, 0, 32'h12BB56DD, 2, 32'h1);
    add(1, 0, 2, 32'h1,        4'hF,   '0,                  1, 0, 0, 32'h12BB56DD, 2, 32'h0);
    add(1, 0, 3, 32'h80000001, 4'hF,   '0,                  1, 0, 0, 32'h12BB56DD, 3, 32'h80000001);
    add(0, 0, 0, 32'h0,        4'h0,   '0,                  0, 0, 0, 32'h12BB56DD, 3, 32'h0);
    add(0, 1, 8, 32'h0,        4'h0,   '0,                  0, 1, 1, 32'h0,        3, 32'h0);
    add(1, 0, 4, 32'hFFFFFFFF, 4'hF,   256'(32'h55) << 128, 0, 1, 0, 32'h0,        4, 32'h55);
    add(1, 1, 0, 32'h5,        4'hF,   '0,                  1, 0, 1, 32'h0,        0, 32'h5);
    add(0, 1, 0, 32'h0,        4'h0,   '0,                  1, 0, 1, 32'h5,        0, 32'h5);
    add(1, 0, 0, 32'hFFFFFFFF, 4'h0,   '0,                  1, 0, 0, 32'h5,        0, 32'h5);
    add(0, 1, 4, 32'h0,        4'h0,   256'(32'h77) << 128, 1, 0, 1, 32'h0,        4, 32'h77);
    add(0, 1, 4, 32'h0,        4'h0,   '0,                  1, 0, 1, 32'h77,       4, 32'h0);
    add(1, 0, 9, 32'h1234,     4'hF,   '0,                  0, 1, 0, 32'h77,       0, 32'h5);
    add(0, 1, 5, 32'h0,        4'h0,   '0,                  1, 0, 1, 32'hCAFEF00D, 5, 32'hCAFEF00D);
    add(0, 1, 6, 32'h0,        4'h0,   '0,                  1, 0, 1, 32'h000000F0, 6, 32'h000000F0);

    foreach (vq[k]) begin
      cycle(0, vq[k].w, vq[k].r, vq[k].a, vq[k].d, vq[k].be, vq[k].st);
      check($sformatf("vec%0d_ack", k), 256'(ack), 256'(vq[k].x_ack));
      check($sformatf("vec%0d_err", k), 256'(err), 256'(vq[k].x_err));
      check($sformatf("vec%0d_rv", k), 256'(rd_valid), 256'(vq[k].x_rv));
      check($sformatf("vec%0d_bus_rd", k), 256'(bus_rd), 256'(vq[k].x_brd));
      check($sformatf("vec%0d_reg", k), 256'(data_out[vq[k].ci*32 +: 32]), 256'(vq[k].creg));
    end

    // Reset in the middle of a back-to-back burst, with live status and access.
    cycle(0, 1, 0, 8'd1, 32'hDEADBEEF, 4'hF, '0);
    cycle(0, 1, 1, 8'd3, 32'hFFFFFFFF, 4'hF, '0);
    cycle(0, 1, 1, 8'd6, 32'hFFFFFFFF, 4'hF, '0);
    cycle(1, 1, 1, 8'd5, 32'h0, 4'hF, '1);
    check("midrst_data_out", data_out, INIT_P);
    check("midrst_resp", {ack, err, rd_valid}, 3'b000);
    check("midrst_bus_rd", 256'(bus_rd), 256'(0));
    cycle(0, 0, 0, 8'd0, 32'h0, 4'h0, 256'(32'hAB) << 128);
    check("post_rst_ro", 256'(data_out[128 +: 32]), 256'(32'hAB));
    check("post_rst_no_resp", {ack, err, rd_valid}, 3'b000);

    // Randomized traffic, back-to-back, with occasional resets.
    for (int n = 0; n < 2000; n++) begin
      for (int j = 0; j < NR; j++) st[j*32 +: 32] = $urandom & $urandom & $urandom;
      cycle(($urandom_range(0, 99) == 0), 1'($urandom), 1'($urandom),
            8'($urandom_range(0, 9)), $urandom, 4'($urandom), st);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
